// File: rtl/btb_pkg.sv
// Shared types and sizing helpers for the branch target buffer.
// Tag, target and counter fields are parameter-width, so they live in arrays beside btb_meta_t.
package btb_pkg;

  typedef enum logic {IDLE, SWEEP} btb_state_t;

  typedef struct packed {
    logic valid;
    logic is_branch;
  } btb_meta_t;

  function automatic int idx_width(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_width(input int pc_width, input int num_sets);
    return pc_width - $clog2(num_sets) - 2;
  endfunction

  function automatic int ptr_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Weakly-taken starting value for a freshly allocated counter
  function automatic int unsigned ctr_init(input int ctr_width);
    return 32'd1 << (ctr_width - 1);
  endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// Fetch-side lookup, resolve-side update and flush signals of the BTB.
interface btb_predictor_if #(
  parameter int PC_WIDTH = 32
);
  logic                lookup_valid;
  logic [PC_WIDTH-1:0] lookup_pc;
  logic                pred_valid;
  logic                pred_hit;
  logic                pred_jump;
  logic                pred_taken;
  logic [PC_WIDTH-1:0] pred_target;
  logic                upd_valid;
  logic [PC_WIDTH-1:0] upd_pc;
  logic [PC_WIDTH-1:0] upd_target;
  logic                upd_is_branch;
  logic                upd_taken;
  logic                flush;
  logic                flush_busy;

  modport master (
    output lookup_valid, lookup_pc,
    output upd_valid, upd_pc, upd_target, upd_is_branch, upd_taken,
    output flush,
    input  pred_valid, pred_hit, pred_jump, pred_taken, pred_target,
    input  flush_busy
  );

  modport slave (
    input  lookup_valid, lookup_pc,
    input  upd_valid, upd_pc, upd_target, upd_is_branch, upd_taken,
    input  flush,
    output pred_valid, pred_hit, pred_jump, pred_taken, pred_target,
    output flush_busy
  );
endinterface

// File: rtl/btb_victim_sel.sv
// Picks the way to allocate into: lowest invalid way, else the round-robin pointer.
module btb_victim_sel #(
  parameter int WAYS  = 2,
  parameter int PTR_W = 1
) (
  input  logic [WAYS-1:0]  valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] victim,
  output logic             advance
);

  always_comb begin
    victim  = ptr;
    advance = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        victim  = PTR_W'(w);
        advance = 1'b0;
      end
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Set-associative BTB with saturating direction counters, round-robin replacement
// and a one-set-per-cycle flush sweep. Predictions are registered one cycle after lookup.
module btb_predictor
  import btb_pkg::*;
#(
  parameter int NUM_SETS  = 16,
  parameter int WAYS      = 2,
  parameter int PC_WIDTH  = 32,
  parameter int CTR_WIDTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  btb_predictor_if.slave  bus
);

  localparam int IDX_W = idx_width(NUM_SETS);
  localparam int TAG_W = tag_width(PC_WIDTH, NUM_SETS);
  localparam int PTR_W = ptr_width(WAYS);
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(ctr_init(CTR_WIDTH));
  localparam logic [IDX_W-1:0]     LAST_SET = IDX_W'(NUM_SETS - 1);
  localparam logic [PTR_W-1:0]     LAST_WAY = PTR_W'(WAYS - 1);

  btb_meta_t            meta    [NUM_SETS][WAYS];
  logic [TAG_W-1:0]     tags    [NUM_SETS][WAYS];
  logic [PC_WIDTH-1:0]  targets [NUM_SETS][WAYS];
  logic [CTR_WIDTH-1:0] ctrs    [NUM_SETS][WAYS];
  logic [PTR_W-1:0]     rr_ptr  [NUM_SETS];

  btb_state_t       state;
  logic [IDX_W-1:0] sweep_set;

  logic [IDX_W-1:0]    lk_set;
  logic [TAG_W-1:0]    lk_tag;
  logic                lk_hit;
  logic                lk_jump;
  logic                lk_taken;
  logic [PC_WIDTH-1:0] lk_target;

  assign lk_set = bus.lookup_pc[IDX_W+1:2];
  assign lk_tag = bus.lookup_pc[PC_WIDTH-1:IDX_W+2];

  // Entries are invisible while the sweep is running
  always_comb begin
    lk_hit    = 1'b0;
    lk_jump   = 1'b0;
    lk_taken  = 1'b0;
    lk_target = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (state == IDLE && meta[lk_set][w].valid && tags[lk_set][w] == lk_tag) begin
        lk_hit    = 1'b1;
        lk_jump   = !meta[lk_set][w].is_branch;
        lk_taken  = !meta[lk_set][w].is_branch || ctrs[lk_set][w][CTR_WIDTH-1];
        lk_target = targets[lk_set][w];
      end
    end
  end

  logic [IDX_W-1:0]     up_set;
  logic [TAG_W-1:0]     up_tag;
  logic                 up_hit;
  logic [PTR_W-1:0]     up_hit_way;
  logic [WAYS-1:0]      up_valid_vec;
  logic [PTR_W-1:0]     victim;
  logic                 advance;
  logic [PTR_W-1:0]     ptr_next;
  logic [CTR_WIDTH-1:0] ctr_cur;
  logic [CTR_WIDTH-1:0] ctr_next;
  logic                 upd_en;
  logic                 alloc_en;

  assign up_set = bus.upd_pc[IDX_W+1:2];
  assign up_tag = bus.upd_pc[PC_WIDTH-1:IDX_W+2];

  always_comb begin
    up_hit       = 1'b0;
    up_hit_way   = '0;
    up_valid_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      up_valid_vec[w] = meta[up_set][w].valid;
      if (meta[up_set][w].valid && tags[up_set][w] == up_tag) begin
        up_hit     = 1'b1;
        up_hit_way = PTR_W'(w);
      end
    end
  end

  btb_victim_sel #(
    .WAYS  (WAYS),
    .PTR_W (PTR_W)
  ) u_victim_sel (
    .valid   (up_valid_vec),
    .ptr     (rr_ptr[up_set]),
    .victim  (victim),
    .advance (advance)
  );

  assign ptr_next = (rr_ptr[up_set] == LAST_WAY) ? '0 : rr_ptr[up_set] + 1'b1;
  assign ctr_cur  = ctrs[up_set][up_hit_way];

  always_comb begin
    ctr_next = ctr_cur;
    if (bus.upd_taken) begin
      if (ctr_cur != '1) ctr_next = ctr_cur + 1'b1;
    end else begin
      if (ctr_cur != '0) ctr_next = ctr_cur - 1'b1;
    end
  end

  assign upd_en   = (state == IDLE) && bus.upd_valid && !bus.flush;
  assign alloc_en = !up_hit && (!bus.upd_is_branch || bus.upd_taken);

  assign bus.flush_busy = (state == SWEEP);

  // Outputs hold between lookups; only pred_valid follows lookup_valid every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= SWEEP;
      sweep_set       <= '0;
      bus.pred_valid  <= 1'b0;
      bus.pred_hit    <= 1'b0;
      bus.pred_jump   <= 1'b0;
      bus.pred_taken  <= 1'b0;
      bus.pred_target <= '0;
    end else begin
      bus.pred_valid <= bus.lookup_valid;
      if (bus.lookup_valid) begin
        bus.pred_hit    <= lk_hit;
        bus.pred_jump   <= lk_jump;
        bus.pred_taken  <= lk_taken;
        bus.pred_target <= lk_target;
      end
      case (state)
        IDLE: begin
          if (bus.flush) begin
            state     <= SWEEP;
            sweep_set <= '0;
          end else if (upd_en) begin
            if (up_hit) begin
              targets[up_set][up_hit_way]        <= bus.upd_target;
              meta[up_set][up_hit_way].is_branch <= bus.upd_is_branch;
              if (bus.upd_is_branch) ctrs[up_set][up_hit_way] <= ctr_next;
            end else if (alloc_en) begin
              meta[up_set][victim]    <= '{valid: 1'b1, is_branch: bus.upd_is_branch};
              tags[up_set][victim]    <= up_tag;
              targets[up_set][victim] <= bus.upd_target;
              ctrs[up_set][victim]    <= CTR_INIT;
              if (advance) rr_ptr[up_set] <= ptr_next;
            end
          end
        end
        SWEEP: begin
          for (int w = 0; w < WAYS; w++) begin
            meta[sweep_set][w].valid <= 1'b0;
          end
          rr_ptr[sweep_set] <= '0;
          if (sweep_set == LAST_SET) state <= IDLE;
          else sweep_set <= sweep_set + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed test of btb_predictor at default parameters with hand-computed expectations.
module tb_btb_predictor;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   busy_count;

  btb_predictor_if #(.PC_WIDTH(32)) bus ();

  btb_predictor #(
    .NUM_SETS  (16),
    .WAYS      (2),
    .PC_WIDTH  (32),
    .CTR_WIDTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic lv, input logic [31:0] lpc,
                               input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                               input logic ub, input logic ut, input logic fl);
    bus.lookup_valid  = lv;
    bus.lookup_pc     = lpc;
    bus.upd_valid     = uv;
    bus.upd_pc        = upc;
    bus.upd_target    = utgt;
    bus.upd_is_branch = ub;
    bus.upd_taken     = ut;
    bus.flush         = fl;
    step();
    bus.lookup_valid = 1'b0;
    bus.upd_valid    = 1'b0;
    bus.flush        = 1'b0;
  endtask

  task automatic doLookup(input logic [31:0] pc);
    applyStimulus(1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doUpdate(input logic [31:0] pc, input logic [31:0] tgt, input logic br, input logic tk);
    applyStimulus(1'b0, 32'h0, 1'b1, pc, tgt, br, tk, 1'b0);
  endtask

  task automatic checkPred(input string name, input logic hit, input logic jump,
                           input logic taken, input logic [31:0] target);
    checkOutput({name, ".valid"},  64'(bus.pred_valid),  64'(1'b1));
    checkOutput({name, ".hit"},    64'(bus.pred_hit),    64'(hit));
    checkOutput({name, ".jump"},   64'(bus.pred_jump),   64'(jump));
    checkOutput({name, ".taken"},  64'(bus.pred_taken),  64'(taken));
    checkOutput({name, ".target"}, 64'(bus.pred_target), 64'(target));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.lookup_valid  = 1'b0;
    bus.lookup_pc     = '0;
    bus.upd_valid     = 1'b0;
    bus.upd_pc        = '0;
    bus.upd_target    = '0;
    bus.upd_is_branch = 1'b0;
    bus.upd_taken     = 1'b0;
    bus.flush         = 1'b0;

    $display("[TB] reset sweep");
    step();
    rst = 1'b0;
    checkOutput("rst.pred_valid",  64'(bus.pred_valid),  64'd0);
    checkOutput("rst.pred_hit",    64'(bus.pred_hit),    64'd0);
    checkOutput("rst.pred_jump",   64'(bus.pred_jump),   64'd0);
    checkOutput("rst.pred_taken",  64'(bus.pred_taken),  64'd0);
    checkOutput("rst.pred_target", 64'(bus.pred_target), 64'd0);
    checkOutput("rst.flush_busy",  64'(bus.flush_busy),  64'd1);
    busy_count = 0;
    while (bus.flush_busy && busy_count < 40) begin
      busy_count++;
      step();
    end
    checkOutput("rst.busy_cycles", 64'(busy_count), 64'd16);

    doLookup(32'h100);
    checkPred("empty_lookup", 1'b0, 1'b0, 1'b0, 32'h0);

    $display("[TB] jump allocate");
    doUpdate(32'h100, 32'h200, 1'b0, 1'b0);
    doLookup(32'h100);
    checkPred("jump_alloc", 1'b1, 1'b1, 1'b1, 32'h200);

    $display("[TB] direction counter");
    doUpdate(32'h104, 32'h300, 1'b1, 1'b1);
    doLookup(32'h104);
    checkPred("br_alloc", 1'b1, 1'b0, 1'b1, 32'h300);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("hold.pred_valid",  64'(bus.pred_valid),  64'd0);
    checkOutput("hold.pred_hit",    64'(bus.pred_hit),    64'd1);
    checkOutput("hold.pred_target", 64'(bus.pred_target), 64'h300);
    doUpdate(32'h104, 32'h300, 1'b1, 1'b0);
    doLookup(32'h104);
    checkPred("ctr_01", 1'b1, 1'b0, 1'b0, 32'h300);
    doUpdate(32'h104, 32'h300, 1'b1, 1'b0);
    doUpdate(32'h104, 32'h300, 1'b1, 1'b0);
    doLookup(32'h104);
    checkPred("ctr_sat_low", 1'b1, 1'b0, 1'b0, 32'h300);
    doUpdate(32'h104, 32'h300, 1'b1, 1'b1);
    doUpdate(32'h104, 32'h300, 1'b1, 1'b1);
    doLookup(32'h104);
    checkPred("ctr_10", 1'b1, 1'b0, 1'b1, 32'h300);
    doUpdate(32'h104, 32'h300, 1'b1, 1'b1);
    doUpdate(32'h104, 32'h300, 1'b1, 1'b1);
    doLookup(32'h104);
    checkPred("ctr_sat_high", 1'b1, 1'b0, 1'b1, 32'h300);
    doUpdate(32'h104, 32'h300, 1'b1, 1'b0);
    doLookup(32'h104);
    checkPred("ctr_11_to_10", 1'b1, 1'b0, 1'b1, 32'h300);
    doUpdate(32'h104, 32'h300, 1'b1, 1'b0);
    doLookup(32'h104);
    checkPred("ctr_10_to_01", 1'b1, 1'b0, 1'b0, 32'h300);

    $display("[TB] no-allocate on not-taken miss");
    doUpdate(32'h108, 32'h380, 1'b1, 1'b0);
    doLookup(32'h108);
    checkPred("nt_miss", 1'b0, 1'b0, 1'b0, 32'h0);

    $display("[TB] round-robin replacement in set 0");
    doUpdate(32'h140, 32'h440, 1'b0, 1'b0);
    doUpdate(32'h180, 32'h480, 1'b0, 1'b0);
    doLookup(32'h100);
    checkPred("evict_100", 1'b0, 1'b0, 1'b0, 32'h0);
    doLookup(32'h140);
    checkPred("keep_140", 1'b1, 1'b1, 1'b1, 32'h440);
    doLookup(32'h180);
    checkPred("keep_180", 1'b1, 1'b1, 1'b1, 32'h480);
    doUpdate(32'h1C0, 32'h4C0, 1'b0, 1'b0);
    doLookup(32'h140);
    checkPred("evict_140", 1'b0, 1'b0, 1'b0, 32'h0);
    doLookup(32'h180);
    checkPred("keep_180b", 1'b1, 1'b1, 1'b1, 32'h480);
    doLookup(32'h1C0);
    checkPred("alloc_1c0", 1'b1, 1'b1, 1'b1, 32'h4C0);

    $display("[TB] same-cycle lookup and update");
    applyStimulus(1'b1, 32'h180, 1'b1, 32'h180, 32'h880, 1'b0, 1'b0, 1'b0);
    checkPred("no_bypass", 1'b1, 1'b1, 1'b1, 32'h480);
    doLookup(32'h180);
    checkPred("after_bypass", 1'b1, 1'b1, 1'b1, 32'h880);

    $display("[TB] flush with update during sweep");
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("flush.busy_start", 64'(bus.flush_busy), 64'd1);
    busy_count = 0;
    if (bus.flush_busy) busy_count++;
    doUpdate(32'h200, 32'h900, 1'b0, 1'b0);
    if (bus.flush_busy) busy_count++;
    applyStimulus(1'b1, 32'h180, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("sweep_lookup.valid", 64'(bus.pred_valid), 64'd1);
    checkOutput("sweep_lookup.hit",   64'(bus.pred_hit),   64'd0);
    while (bus.flush_busy && busy_count < 40) begin
      busy_count++;
      step();
    end
    checkOutput("flush.busy_cycles", 64'(busy_count), 64'd16);
    doLookup(32'h200);
    checkPred("dropped_upd", 1'b0, 1'b0, 1'b0, 32'h0);
    doLookup(32'h180);
    checkPred("flushed_180", 1'b0, 1'b0, 1'b0, 32'h0);
    doLookup(32'h1C0);
    checkPred("flushed_1c0", 1'b0, 1'b0, 1'b0, 32'h0);
    doLookup(32'h104);
    checkPred("flushed_104", 1'b0, 1'b0, 1'b0, 32'h0);
    doUpdate(32'h200, 32'h900, 1'b0, 1'b0);
    doLookup(32'h200);
    checkPred("post_flush_alloc", 1'b1, 1'b1, 1'b1, 32'h900);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
